spectro_frame_accumulator: RTL
==============================

Name: spectro_frame_accumulator

Overview:
Downstream stage of the 7-channel priority encoder. Consumes the 3-bit decoded channel code (0 = no channel active, 1..7 = highest active band) and builds one spectrogram column per frame of FRAME_LEN samples. The column is a histogram of 8 bins, counting how often each code occurred. Completed columns are double-buffered, then streamed out bin by bin over a valid/ready handshake, so accumulation of the next frame never stalls.

Parameters:
FRAME_LEN, 256, samples per frame; legal range 1..65535.
CNT_W, 8, width of each bin counter and of out_count.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
sample_en  input  1  channel_decode is a valid sample this cycle.
channel_decode  input  3  decoded channel code from the encoder stage.
out_valid  output  1  out_bin/out_count hold a valid beat.
out_ready  input  1  consumer accepts the beat this cycle.
out_bin  output  3  bin index of the current beat, 0..7.
out_count  output  CNT_W  count for out_bin in the completed frame.
frame_done  output  1  one-cycle pulse when a completed frame is loaded for readout.
overrun  output  1  sticky; a completed frame was dropped because readout was busy.

Behaviour:
- Reset (rst=1 at a clock edge): every output becomes 0 at that edge. The sample counter, all accumulate and readout bins, the readout index and the FSM (IDLE) are cleared. Applies mid-frame and mid-readout; any partial frame and any pending readout are discarded.
- Accumulate bank: 8 counters of CNT_W bits each.
  - On sample_en=1, bin[channel_decode] increments by 1, saturating at 2^CNT_W-1 with no wrap.
  - sample_en=0 cycles are ignored completely.
- Sample counter: ceil(log2(FRAME_LEN)) bits, minimum 1 bit. Increments on each sample_en.
- Frame completion: a frame completes on the cycle where sample_en=1 and sample counter = FRAME_LEN-1.
  - The completing sample is included in the frame.
  - The sample counter returns to 0.
  - The accumulate bank is cleared for the next frame, regardless of whether the frame was kept or dropped.
- Readout is free at completion when either:
  - the FSM is IDLE, or
  - the FSM is in SEND and the bin-7 beat is handshaken in that same cycle.
- If readout is free at completion:
  - The readout bank loads the final counts, including the completing sample.
  - FSM enters SEND with index 0.
  - frame_done=1 for exactly the next cycle.
  - out_valid=1 from the next cycle. Latency is 1 cycle after the completing sample.
- If readout is not free at completion: the frame is dropped, overrun is set to 1 and stays 1 until reset, and the readout bank is left untouched.
- FSM states:
  - IDLE: out_valid=0. out_bin and out_count are held at their last values (0 after reset).
  - SEND: out_valid=1, out_bin=index, out_count=readout[index].
    - On out_valid and out_ready, index increments.
    - After the index-7 handshake, go to IDLE, unless a new frame loads in the same cycle, in which case go to SEND with index 0.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_bin and out_count hold stable.
  - out_valid never drops without a handshake, except on reset.
  - out_ready is ignored while out_valid=0.
- Exactly 8 beats per frame, always in order bin 0..7. Bins with zero count are still sent.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. FRAME_LEN=8, out_ready=1, samples with sample_en=1: codes 1,1,3,7,0,0,0,5.
   - Cycle after the 8th sample: out_valid=1 and frame_done pulses once.
   - Beats (bin,count): (0,3),(1,2),(2,0),(3,1),(4,0),(5,1),(6,0),(7,1) on 8 consecutive cycles, then out_valid=0.
2. Same stimulus with out_ready held 0 for 5 cycles while bin 2 is presented.
   - (2,0) is held stable for the full stall; no beat is skipped or duplicated; total of 8 beats.
3. FRAME_LEN=8, out_ready=0 throughout, 16 samples sent.
   - overrun goes to 1 after the 16th sample.
   - When out_ready is then raised, the first frame's beats appear intact; frame_done pulses only once.
4. FRAME_LEN=8, out_ready timed so the bin-7 handshake coincides with the next frame's completing sample.
   - overrun stays 0 and bin 0 of the new frame is presented on the next cycle.
5. CNT_W=3, FRAME_LEN=12, all samples code 4, with sample_en toggled 1,0,1,0 so 24 cycles carry 12 samples.
   - Bin 4 count is 7 (saturated); all other bins are 0.
   - Frame completes only on the 12th enabled sample.
6. Assert rst for one cycle mid-frame (after 5 samples), then again mid-readout (during bin 3).
   - All outputs are 0 on the next cycle.
   - The next frame counts from zero with no residue from the discarded data.

Source files
------------

// File: rtl/spectro_frame_accumulator_if.sv
// Sample input and column readout bundle for the spectrogram frame accumulator.
// The master drives samples and out_ready; the slave (accumulator) drives the beats.
interface spectro_frame_accumulator_if #(
  parameter int CNT_W = 8
);
  logic             sample_en;
  logic [2:0]       channel_decode;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_bin;
  logic [CNT_W-1:0] out_count;
  logic             frame_done;
  logic             overrun;

  modport master (
    output sample_en, channel_decode, out_ready,
    input  out_valid, out_bin, out_count, frame_done, overrun
  );

  modport slave (
    input  sample_en, channel_decode, out_ready,
    output out_valid, out_bin, out_count, frame_done, overrun
  );
endinterface

// File: rtl/spectro_frame_accumulator.sv
// Builds an 8-bin histogram column per frame of channel codes, double-buffers
// completed columns and streams them out bin by bin over valid/ready.
module spectro_frame_accumulator #(
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = 8
) (
  input logic                        clk,
  input logic                        rst,
  spectro_frame_accumulator_if.slave bus
);
  localparam int SCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [SCW-1:0] LAST = SCW'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] MAX = '1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  state_t           state_nx;
  logic [2:0]       idx;
  logic [2:0]       idx_nx;
  logic [SCW-1:0]   scnt;
  logic [CNT_W-1:0] acc    [8];
  logic [CNT_W-1:0] acc_nx [8];
  logic [CNT_W-1:0] rdb    [8];
  logic             hs;
  logic             last_beat;
  logic             complete;
  logic             free;
  logic             load;
  logic             frame_done_q;
  logic             overrun_q;

  // Saturating increment of the addressed bin, including the current sample.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      acc_nx[i] = acc[i];
      if (bus.sample_en && bus.channel_decode == 3'(i) && acc[i] != MAX)
        acc_nx[i] = acc[i] + CNT_W'(1);
    end
  end

  // Readout FSM next state; a frame may reload on the bin-7 handshake.
  always_comb begin
    hs        = (state == SEND) && bus.out_ready;
    last_beat = hs && (idx == 3'd7);
    complete  = bus.sample_en && (scnt == LAST);
    free      = (state == IDLE) || last_beat;
    load      = complete && free;
    state_nx  = state;
    idx_nx    = idx;
    unique case (state)
      IDLE: begin
        if (load) begin
          state_nx = SEND;
          idx_nx   = 3'd0;
        end
      end
      SEND: begin
        if (load) begin
          state_nx = SEND;
          idx_nx   = 3'd0;
        end else if (last_beat) begin
          state_nx = IDLE;
        end else if (hs) begin
          idx_nx = idx + 3'd1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // FSM state and readout index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 3'd0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Sample counter, accumulate bank, readout bank and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt         <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        acc[i] <= '0;
        rdb[i] <= '0;
      end
    end else begin
      if (bus.sample_en)
        scnt <= complete ? '0 : scnt + SCW'(1);
      for (int i = 0; i < 8; i++) begin
        acc[i] <= complete ? '0 : acc_nx[i];
        if (load)
          rdb[i] <= acc_nx[i];
      end
      frame_done_q <= load;
      overrun_q    <= overrun_q | (complete & ~free);
    end
  end

  assign bus.out_valid  = (state == SEND);
  assign bus.out_bin    = idx;
  assign bus.out_count  = rdb[idx];
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;
endmodule
